// File: rtl/mfp_ahb_lite_matrix_n_if.sv
// AHB-Lite single-master matrix bundle: CPU-side bus, per-slave fan-out
// and the error-capture status used by software/debug.
interface mfp_ahb_lite_matrix_n_if #(
  parameter int unsigned N_SLAVES = 5
);
  // CPU (master) side
  logic [31:0]            HADDR;
  logic [1:0]             HTRANS;
  logic                   HWRITE;
  logic [31:0]            HRDATA;
  logic                   HREADY;
  logic                   HRESP;

  // Slave side
  logic [N_SLAVES-1:0]    S_HSEL;
  logic [N_SLAVES-1:0]    S_HREADYOUT;
  logic [N_SLAVES*32-1:0] S_HRDATA;
  logic [N_SLAVES-1:0]    S_HRESP;

  // Error capture
  logic                   ERR_CLEAR;
  logic                   ERR_VALID;
  logic [31:0]            ERR_ADDR;
  logic                   ERR_WRITE;

  // View taken by the matrix itself (it is the slave of the CPU)
  modport slave (
    input  HADDR, HTRANS, HWRITE, S_HREADYOUT, S_HRDATA, S_HRESP, ERR_CLEAR,
    output HRDATA, HREADY, HRESP, S_HSEL, ERR_VALID, ERR_ADDR, ERR_WRITE
  );

  // View taken by the CPU / slave models driving the matrix
  modport master (
    output HADDR, HTRANS, HWRITE, S_HREADYOUT, S_HRDATA, S_HRESP, ERR_CLEAR,
    input  HRDATA, HREADY, HRESP, S_HSEL, ERR_VALID, ERR_ADDR, ERR_WRITE
  );
endinterface

// File: rtl/mfp_ahb_lite_matrix_n.sv
// Parametrised AHB-Lite single-master interconnect: base/mask address
// decode with lowest-index priority, registered data-phase response mux,
// internal default slave giving the two-cycle ERROR response for unmapped
// active transfers, and a sticky first-error capture register.
module mfp_ahb_lite_matrix_n #(
  parameter int unsigned            N_SLAVES   = 5,
  parameter logic [N_SLAVES*32-1:0] SLAVE_BASE = {32'h10402000, 32'h10401000,
                                                  32'h1F800000, 32'h00000000,
                                                  32'h1FC00000},
  parameter logic [N_SLAVES*32-1:0] SLAVE_MASK = {32'h1FFFF000, 32'h1FFFF000,
                                                  32'h1FC00000, 32'h1C000000,
                                                  32'h1FC00000}
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  mfp_ahb_lite_matrix_n_if.slave bus
);

  localparam int unsigned IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  // Data-phase owner: an external slave (index held separately), the
  // internal default slave, or nobody (zero-wait OKAY).
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_SLAVE,
    SEL_DEFAULT
  } sel_kind_e;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } ds_state_e;

  // Address decode
  logic [N_SLAVES-1:0] match;
  logic [N_SLAVES-1:0] hsel;
  logic                hit;
  logic [IDX_W-1:0]    hit_idx;

  // Data-phase select
  sel_kind_e           sel_kind_q, sel_kind_d;
  logic [IDX_W-1:0]    sel_idx_q,  sel_idx_d;

  // Default slave
  ds_state_e           ds_q, ds_d;
  logic                ds_ready;
  logic                ds_resp;

  // Error capture
  logic                err_valid_q, err_valid_d;
  logic [31:0]         err_addr_q,  err_addr_d;
  logic                err_write_q, err_write_d;

  // Response mux
  logic [31:0]         s_rdata [N_SLAVES];
  logic                hready;
  logic                hresp;
  logic [31:0]         hrdata;
  logic                err_start;

  // Compare every window against the current address
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      match[i] = ((bus.HADDR & SLAVE_MASK[32*i +: 32]) ==
                  (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32]));
    end
  end

  // Lowest matching index wins; select is independent of HTRANS
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hsel    = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (match[i] && !hit) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
        hsel[i] = 1'b1;
      end
    end
  end

  // Unpack the per-slave read data bus
  always_comb begin
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      s_rdata[i] = bus.S_HRDATA[32*i +: 32];
    end
  end

  // An unmapped active transfer is being accepted this cycle
  assign err_start = hready && bus.HTRANS[1] && !hit;

  // Default-slave outputs, decoded from the state alone
  always_comb begin
    ds_ready = 1'b1;
    ds_resp  = 1'b0;
    case (ds_q)
      DS_ERR1: begin
        ds_ready = 1'b0;
        ds_resp  = 1'b1;
      end
      DS_ERR2: begin
        ds_resp  = 1'b1;
      end
      default: ;
    endcase
  end

  // Default-slave next state; ERR2 chains straight into a new ERROR pair
  always_comb begin
    ds_d = ds_q;
    case (ds_q)
      DS_IDLE: if (err_start) ds_d = DS_ERR1;
      DS_ERR1: ds_d = DS_ERR2;
      DS_ERR2: ds_d = err_start ? DS_ERR1 : DS_IDLE;
      default: ds_d = DS_IDLE;
    endcase
  end

  // Route the data-phase owner's response back to the master
  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    case (sel_kind_q)
      SEL_SLAVE: begin
        hready = bus.S_HREADYOUT[sel_idx_q];
        hresp  = bus.S_HRESP[sel_idx_q];
        hrdata = s_rdata[sel_idx_q];
      end
      SEL_DEFAULT: begin
        hready = ds_ready;
        hresp  = ds_resp;
      end
      default: ;
    endcase
  end

  // Data-phase select advances only when the bus is ready
  always_comb begin
    sel_kind_d = sel_kind_q;
    sel_idx_d  = sel_idx_q;
    if (hready) begin
      if (hit) begin
        sel_kind_d = SEL_SLAVE;
        sel_idx_d  = hit_idx;
      end else if (bus.HTRANS[1]) begin
        sel_kind_d = SEL_DEFAULT;
      end else begin
        sel_kind_d = SEL_NONE;
      end
    end
  end

  // Sticky first-error capture; a clear in the same cycle as a new error
  // frees the slot so the new error is recorded
  always_comb begin
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    err_write_d = err_write_q;
    if (err_start && (!err_valid_q || bus.ERR_CLEAR)) begin
      err_valid_d = 1'b1;
      err_addr_d  = bus.HADDR;
      err_write_d = bus.HWRITE;
    end else if (bus.ERR_CLEAR) begin
      err_valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_kind_q  <= SEL_NONE;
      sel_idx_q   <= '0;
      ds_q        <= DS_IDLE;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_write_q <= 1'b0;
    end else begin
      sel_kind_q  <= sel_kind_d;
      sel_idx_q   <= sel_idx_d;
      ds_q        <= ds_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_write_q <= err_write_d;
    end
  end

  assign bus.S_HSEL    = hsel;
  assign bus.HREADY    = hready;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = hrdata;
  assign bus.ERR_VALID = err_valid_q;
  assign bus.ERR_ADDR  = err_addr_q;
  assign bus.ERR_WRITE = err_write_q;

endmodule

// File: tb/tb_mfp_ahb_lite_matrix_n.sv
// Testbench for mfp_ahb_lite_matrix_n: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_mfp_ahb_lite_matrix_n;

  localparam int N = 5;
  localparam logic [N*32-1:0] DEF_BASE = {32'h10402000, 32'h10401000, 32'h1F800000,
                                          32'h00000000, 32'h1FC00000};
  localparam logic [N*32-1:0] DEF_MASK = {32'h1FFFF000, 32'h1FFFF000, 32'h1FC00000,
                                          32'h1C000000, 32'h1FC00000};
  // Second instance: slave 1 window duplicates slave 3's window
  localparam logic [N*32-1:0] OVL_BASE = {32'h10402000, 32'h10401000, 32'h1F800000,
                                          32'h10401000, 32'h1FC00000};
  localparam logic [N*32-1:0] OVL_MASK = {32'h1FFFF000, 32'h1FFFF000, 32'h1FC00000,
                                          32'h1FFFF000, 32'h1FC00000};

  logic HCLK;
  logic HRESETn;

  mfp_ahb_lite_matrix_n_if #(.N_SLAVES(N)) bus ();
  mfp_ahb_lite_matrix_n_if #(.N_SLAVES(N)) bus2 ();

  mfp_ahb_lite_matrix_n #(.N_SLAVES(N)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  mfp_ahb_lite_matrix_n #(
    .N_SLAVES   (N),
    .SLAVE_BASE (OVL_BASE),
    .SLAVE_MASK (OVL_MASK)
  ) dut_ovl (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus2)
  );

  assign bus2.HADDR       = bus.HADDR;
  assign bus2.HTRANS      = bus.HTRANS;
  assign bus2.HWRITE      = bus.HWRITE;
  assign bus2.S_HREADYOUT = bus.S_HREADYOUT;
  assign bus2.S_HRDATA    = bus.S_HRDATA;
  assign bus2.S_HRESP     = bus.S_HRESP;
  assign bus2.ERR_CLEAR   = bus.ERR_CLEAR;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the data phase (-1 nobody, 0..N-1 slave,
  // N default slave), remaining ERROR cycles, and the error log.
  int          m_sel;
  int          m_err;
  logic        m_ev;
  logic [31:0] m_ea;
  logic        m_ew;

  task automatic model_reset();
    m_sel = -1;
    m_err = 0;
    m_ev  = 1'b0;
    m_ea  = '0;
    m_ew  = 1'b0;
  endtask

  function automatic int decode(logic [31:0] a, bit ovl);
    logic [N*32-1:0] b, m;
    b = ovl ? OVL_BASE : DEF_BASE;
    m = ovl ? OVL_MASK : DEF_MASK;
    for (int i = 0; i < N; i++)
      if ((a & m[32*i +: 32]) == (b[32*i +: 32] & m[32*i +: 32])) return i;
    return -1;
  endfunction

  function automatic void exp_resp(output logic r, output logic p, output logic [31:0] d);
    r = 1'b1;
    p = 1'b0;
    d = '0;
    if (m_sel >= 0 && m_sel < N) begin
      r = bus.S_HREADYOUT[m_sel];
      p = bus.S_HRESP[m_sel];
      d = bus.S_HRDATA[32*m_sel +: 32];
    end else if (m_sel == N) begin
      r = (m_err != 2);
      p = 1'b1;
    end
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic        r, p;
    logic [31:0] d;
    int          w, w2;
    exp_resp(r, p, d);
    w  = decode(bus.HADDR, 1'b0);
    w2 = decode(bus.HADDR, 1'b1);
    chk({tag, ".hsel"},     32'(bus.S_HSEL),  (w  < 0) ? 32'd0 : (32'd1 << w));
    chk({tag, ".hsel_ovl"}, 32'(bus2.S_HSEL), (w2 < 0) ? 32'd0 : (32'd1 << w2));
    chk({tag, ".hready"},   32'(bus.HREADY),  32'(r));
    chk({tag, ".hresp"},    32'(bus.HRESP),   32'(p));
    chk({tag, ".hrdata"},   bus.HRDATA,       d);
    chk({tag, ".ev"},       32'(bus.ERR_VALID), 32'(m_ev));
    chk({tag, ".ea"},       bus.ERR_ADDR,     m_ea);
    chk({tag, ".ew"},       32'(bus.ERR_WRITE), 32'(m_ew));
  endtask

  // Advance the model across one rising edge using the current inputs
  task automatic model_step();
    logic        r, p;
    logic [31:0] d;
    int          w;
    exp_resp(r, p, d);
    w = decode(bus.HADDR, 1'b0);
    if (r) begin
      if (w >= 0) m_sel = w;
      else if (bus.HTRANS[1]) begin
        m_sel = N;
        m_err = 2;
      end else m_sel = -1;
    end else if (m_sel == N) begin
      m_err = 1;
    end
    if (bus.ERR_CLEAR) m_ev = 1'b0;
    if (r && w < 0 && bus.HTRANS[1] && !m_ev) begin
      m_ev = 1'b1;
      m_ea = bus.HADDR;
      m_ew = bus.HWRITE;
    end
  endtask

  task automatic tick(string tag);
    #1;
    check_all(tag);
    model_step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus();
    bus.HADDR     = '0;
    bus.HTRANS    = 2'b00;
    bus.HWRITE    = 1'b0;
    bus.ERR_CLEAR = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] top;
    top = $urandom & 32'hE0000000;
    case ($urandom_range(0, 6))
      0: return top | 32'h1FC00000 | ($urandom & 32'h003FFFFF);
      1: return $urandom & 32'hE3FFFFFF;
      2: return top | 32'h1F800000 | ($urandom & 32'h003FFFFF);
      3: return top | 32'h10401000 | ($urandom & 32'h00000FFF);
      4: return top | 32'h10402000 | ($urandom & 32'h00000FFF);
      5: return top | 32'h12340000 | ($urandom & 32'h0000FFFF);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn         = 1'b0;
    idle_bus();
    bus.S_HREADYOUT = '1;
    bus.S_HRESP     = '0;
    bus.S_HRDATA    = {5{$urandom}};
    model_reset();
    #2;
    check_all("reset");
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    // Pipelined reads with slave 0 stalling two cycles
    bus.HADDR = 32'h1FC00004; bus.HTRANS = 2'b10;
    #1; chk("rd0.hsel", 32'(bus.S_HSEL), 32'h01);
    tick("rd0");
    bus.HADDR = 32'h1F800008; bus.S_HREADYOUT[0] = 1'b0;
    #1; chk("rd1.hsel", 32'(bus.S_HSEL), 32'h04); chk("stall1.hready", 32'(bus.HREADY), 32'd0);
    tick("stall1");
    #1; chk("stall2.hready", 32'(bus.HREADY), 32'd0);
    tick("stall2");
    bus.S_HREADYOUT[0] = 1'b1; bus.S_HRDATA[31:0] = 32'hAAAA5555;
    #1; chk("rd0.data", bus.HRDATA, 32'hAAAA5555); chk("rd0.hready", 32'(bus.HREADY), 32'd1);
    tick("rd0_data");
    idle_bus(); bus.S_HRDATA[95:64] = 32'h22220002;
    #1; chk("rd1.data", bus.HRDATA, 32'h22220002);
    tick("rd1_data");

    // Unmapped NONSEQ read
    bus.HADDR = 32'h12340000; bus.HTRANS = 2'b10;
    tick("unm_addr");
    idle_bus();
    #1; chk("unm.err1.hready", 32'(bus.HREADY), 32'd0); chk("unm.err1.hresp", 32'(bus.HRESP), 32'd1);
    tick("unm_err1");
    #1; chk("unm.err2.hready", 32'(bus.HREADY), 32'd1); chk("unm.err2.hresp", 32'(bus.HRESP), 32'd1);
    chk("unm.ev", 32'(bus.ERR_VALID), 32'd1); chk("unm.ea", bus.ERR_ADDR, 32'h12340000);
    chk("unm.ew", 32'(bus.ERR_WRITE), 32'd0);
    tick("unm_err2");

    // Unmapped IDLE: zero-wait OKAY, log untouched
    bus.HADDR = 32'h12340000; bus.HTRANS = 2'b00;
    tick("idle_unm_addr");
    #1; chk("idle_unm.hready", 32'(bus.HREADY), 32'd1); chk("idle_unm.hresp", 32'(bus.HRESP), 32'd0);
    chk("idle_unm.ev", 32'(bus.ERR_VALID), 32'd1);
    tick("idle_unm_data");

    // Clear the log
    bus.ERR_CLEAR = 1'b1;
    tick("clear");
    idle_bus();
    #1; chk("clear.ev", 32'(bus.ERR_VALID), 32'd0);
    tick("after_clear");

    // Overlapping windows: lower index wins
    bus.HADDR = 32'h10401000; bus.HTRANS = 2'b10;
    #1; chk("ovl.main", 32'(bus.S_HSEL), 32'h08); chk("ovl.dup", 32'(bus2.S_HSEL), 32'h02);
    tick("ovl");
    idle_bus();
    tick("ovl_idle");

    // Back-to-back unmapped writes, clear pulsed on the second capture
    bus.HADDR = 32'h13000000; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1;
    tick("b2b_a");
    bus.HADDR = 32'h14000000;
    #1; chk("b2b.e1.hready", 32'(bus.HREADY), 32'd0); chk("b2b.e1.hresp", 32'(bus.HRESP), 32'd1);
    tick("b2b_e1");
    bus.ERR_CLEAR = 1'b1;
    #1; chk("b2b.e2.hready", 32'(bus.HREADY), 32'd1); chk("b2b.first.ea", bus.ERR_ADDR, 32'h13000000);
    tick("b2b_e2");
    idle_bus();
    #1; chk("b2b.e3.hready", 32'(bus.HREADY), 32'd0); chk("b2b.ev", 32'(bus.ERR_VALID), 32'd1);
    chk("b2b.ea", bus.ERR_ADDR, 32'h14000000); chk("b2b.ew", 32'(bus.ERR_WRITE), 32'd1);
    tick("b2b_e3");
    #1; chk("b2b.e4.hresp", 32'(bus.HRESP), 32'd1);
    tick("b2b_e4");
    #1; chk("b2b.done.hresp", 32'(bus.HRESP), 32'd0);
    tick("b2b_done");

    // Asynchronous reset in the middle of DS_ERR1
    bus.HADDR = 32'h15000000; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0;
    tick("rst_addr");
    bus.HADDR = 32'h1FC00000; bus.HTRANS = 2'b00;
    #1; chk("rst.pre.hready", 32'(bus.HREADY), 32'd0);
    #1; HRESETn = 1'b0; model_reset();
    #1; chk("rst.hready", 32'(bus.HREADY), 32'd1); chk("rst.hresp", 32'(bus.HRESP), 32'd0);
    chk("rst.ev", 32'(bus.ERR_VALID), 32'd0); chk("rst.hsel", 32'(bus.S_HSEL), 32'h01);
    check_all("rst_mid");
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick("post_rst");

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      bus.HADDR       = pick_addr();
      bus.HTRANS      = 2'($urandom_range(0, 3));
      bus.HWRITE      = 1'($urandom);
      bus.ERR_CLEAR   = ($urandom_range(0, 7) == 0);
      bus.S_HREADYOUT = 5'($urandom) | 5'($urandom);
      bus.S_HRESP     = 5'($urandom) & 5'($urandom) & 5'($urandom);
      bus.S_HRDATA    = {5{$urandom}};
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
